// File: rtl/room_sequencer_if.sv
// Room sequencer bus: exit events and stepper handshake toward the scene/video side.
interface room_sequencer_if;
  logic       exit_right;
  logic       exit_left;
  logic       underground;
  logic [7:0] map_in;
  logic       step;
  logic       dir;
  logic       load_seed;
  logic [7:0] seed_out;
  logic [7:0] room;
  logic [7:0] room_idx;
  logic       blank;
  logic       busy;
  logic       done;

  // Sequencer side
  modport master (
    input  exit_right, exit_left, underground, map_in,
    output step, dir, load_seed, seed_out, room, room_idx, blank, busy, done
  );

  // Environment side (player logic, LFSR stepper, video)
  modport slave (
    output exit_right, exit_left, underground, map_in,
    input  step, dir, load_seed, seed_out, room, room_idx, blank, busy, done
  );
endinterface

// File: rtl/room_sequencer.sv
// Room sequencer: turns screen exits into map LFSR steps, blanks video while the
// stepper advances, and commits the new room byte and room index (mod 255).
module room_sequencer #(
  parameter logic [7:0]  START_SEED        = 8'hC4,
  parameter int unsigned UNDERGROUND_STEPS = 3,
  parameter int unsigned BLANK_CYCLES      = 16
) (
  input logic             clk,
  input logic             rst_n,
  room_sequencer_if.master bus
);

  localparam int unsigned CntW = $clog2(BLANK_CYCLES + 1);

  typedef enum logic [2:0] {
    StLoad, StSync, StIdle, StStep, StWait, StBlank, StCommit
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      steps_left_q, steps_left_d;
  logic [3:0]      n_steps_q, n_steps_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dir_q, dir_d;
  logic [7:0]      room_q, room_d;
  logic [7:0]      idx_q, idx_d;
  logic [8:0]      idx_up, idx_dn;
  logic [7:0]      idx_next;

  // Index arithmetic modulo 255 using 9-bit intermediates; 255 is never produced.
  always_comb begin
    idx_up = {1'b0, idx_q} + {5'd0, n_steps_q};
    if (idx_up >= 9'd255) idx_up = idx_up - 9'd255;
    idx_dn = {1'b0, idx_q} - {5'd0, n_steps_q};
    if (idx_dn[8]) idx_dn = idx_dn + 9'd255;
    idx_next = dir_q ? idx_up[7:0] : idx_dn[7:0];
  end

  // Next-state logic for the transition sequence.
  always_comb begin
    state_d      = state_q;
    steps_left_d = steps_left_q;
    n_steps_d    = n_steps_q;
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    room_d       = room_q;
    idx_d        = idx_q;
    unique case (state_q)
      StLoad: state_d = StSync;
      StSync: begin
        room_d  = bus.map_in;
        state_d = StIdle;
      end
      StIdle: begin
        // Simultaneous left/right exits are ambiguous and ignored.
        if (bus.exit_right ^ bus.exit_left) begin
          dir_d        = bus.exit_right;
          steps_left_d = bus.underground ? 4'(UNDERGROUND_STEPS) : 4'd1;
          n_steps_d    = bus.underground ? 4'(UNDERGROUND_STEPS) : 4'd1;
          state_d      = StStep;
        end
      end
      StStep: state_d = StWait;
      StWait: begin
        steps_left_d = steps_left_q - 4'd1;
        if (steps_left_q == 4'd1) begin
          cnt_d   = CntW'(BLANK_CYCLES);
          state_d = StBlank;
        end else begin
          state_d = StStep;
        end
      end
      StBlank: begin
        // Commit on the edge into COMMIT so the new room is visible alongside done.
        if (cnt_q == CntW'(1)) begin
          room_d  = bus.map_in;
          idx_d   = idx_next;
          state_d = StCommit;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StCommit: state_d = StIdle;
      default:  state_d = StLoad;
    endcase
  end

  // State and datapath registers; reset aborts any transition in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StLoad;
      steps_left_q <= 4'd0;
      n_steps_q    <= 4'd0;
      cnt_q        <= '0;
      dir_q        <= 1'b1;
      room_q       <= START_SEED;
      idx_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      steps_left_q <= steps_left_d;
      n_steps_q    <= n_steps_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      room_q       <= room_d;
      idx_q        <= idx_d;
    end
  end

  // Outputs decoded from state; load_seed is gated so it stays low while reset is held.
  always_comb begin
    bus.step      = (state_q == StStep);
    bus.load_seed = (state_q == StLoad) && rst_n;
    bus.done      = (state_q == StCommit);
    bus.blank     = (state_q != StIdle);
    bus.busy      = (state_q != StIdle);
    bus.dir       = dir_q;
    bus.seed_out  = START_SEED;
    bus.room      = room_q;
    bus.room_idx  = idx_q;
  end

endmodule

// File: tb/tb_room_sequencer.sv
// Self-checking bench for room_sequencer: behavioural LFSR stepper plus a
// scoreboard of expected {room, room_idx} pushed per exit and popped on done.
module tb_room_sequencer;

  localparam int BlankCycles = 16;
  localparam int UgSteps     = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] map = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  exp_room;
  int          exp_idx;

  room_sequencer_if bus ();

  room_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Forward step: Fibonacci x^8+x^6+x^5+x^4+1, left shift (period 255).
  function automatic logic [7:0] lfsr_fwd(input logic [7:0] m);
    return {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
  endfunction

  // Inverse of lfsr_fwd, right shift.
  function automatic logic [7:0] lfsr_bwd(input logic [7:0] n);
    return {n[0] ^ n[6] ^ n[5] ^ n[4], n[7:1]};
  endfunction

  // Stepper model driven by the DUT strobes.
  always @(posedge clk) begin
    if (bus.load_seed === 1'b1) map <= bus.seed_out;
    else if (bus.step === 1'b1) map <= bus.dir ? lfsr_fwd(map) : lfsr_bwd(map);
  end
  assign bus.map_in = map;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("done_without_exit", {31'd0, bus.done}, 32'd0);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check_eq("room_at_done", {24'd0, bus.room}, {24'd0, e[15:8]});
        check_eq("idx_at_done", {24'd0, bus.room_idx}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic run_exit(input bit r, input bit l, input bit ug, input int repulse_at);
    int n;
    int done_cyc;
    int busy_low;
    int step_cyc[$];
    n = ug ? UgSteps : 1;
    for (int i = 0; i < n; i++) exp_room = r ? lfsr_fwd(exp_room) : lfsr_bwd(exp_room);
    exp_idx = r ? (exp_idx + n) % 255 : (exp_idx + 255 - n) % 255;
    exp_q.push_back({exp_room, 8'(exp_idx)});
    @(negedge clk);
    bus.exit_right  = r;
    bus.exit_left   = l;
    bus.underground = ug;
    @(posedge clk);
    #1;
    bus.exit_right = 1'b0;
    bus.exit_left  = 1'b0;
    done_cyc = 0;
    busy_low = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) check_eq("dir_at_accept", {31'd0, bus.dir}, {31'd0, r});
      if (k == 2) bus.underground = ~ug;
      if (repulse_at != 0 && k == repulse_at) bus.exit_right = 1'b1;
      if (repulse_at != 0 && k == repulse_at + 1) bus.exit_right = 1'b0;
      if (bus.busy !== 1'b1 || bus.blank !== 1'b1) busy_low++;
      if (bus.step === 1'b1) step_cyc.push_back(k);
      if (bus.done === 1'b1) begin
        done_cyc = k;
        break;
      end
    end
    bus.exit_right  = 1'b0;
    bus.underground = 1'b0;
    check_eq("done_cycle", done_cyc, 2 * n + BlankCycles + 1);
    check_eq("step_count", step_cyc.size(), n);
    for (int i = 0; i < step_cyc.size() && i < n; i++)
      check_eq("step_cycle", step_cyc[i], 2 * i + 1);
    check_eq("busy_blank_held", busy_low, 0);
  endtask

  initial begin
    int bad;
    bus.exit_right  = 1'b0;
    bus.exit_left   = 1'b0;
    bus.underground = 1'b0;
    exp_room = 8'hC4;
    exp_idx  = 0;

    // Reset held for three cycles
    repeat (3) @(negedge clk);
    check_eq("rst_load_seed", {31'd0, bus.load_seed}, 0);
    check_eq("rst_step", {31'd0, bus.step}, 0);
    check_eq("rst_done", {31'd0, bus.done}, 0);
    check_eq("rst_dir", {31'd0, bus.dir}, 1);
    check_eq("rst_blank", {31'd0, bus.blank}, 1);
    check_eq("rst_busy", {31'd0, bus.busy}, 1);
    check_eq("rst_room", {24'd0, bus.room}, 32'hC4);
    check_eq("rst_idx", {24'd0, bus.room_idx}, 0);
    rst_n = 1'b1;
    #1;
    check_eq("load_seed_first", {31'd0, bus.load_seed}, 1);
    check_eq("seed_out", {24'd0, bus.seed_out}, 32'hC4);
    @(negedge clk);
    check_eq("load_seed_once", {31'd0, bus.load_seed}, 0);
    repeat (2) @(negedge clk);
    check_eq("busy_after_init", {31'd0, bus.busy}, 0);
    check_eq("blank_after_init", {31'd0, bus.blank}, 0);
    check_eq("room_after_init", {24'd0, bus.room}, 32'hC4);
    check_eq("idx_after_init", {24'd0, bus.room_idx}, 0);

    // Full period round trip
    for (int i = 0; i < 255; i++) run_exit(1'b1, 1'b0, 1'b0, 0);
    check_eq("roundtrip_room", {24'd0, bus.room}, 32'hC4);
    check_eq("roundtrip_idx", {24'd0, bus.room_idx}, 0);

    // Walk to idx 5, then single right exit
    for (int i = 0; i < 5; i++) run_exit(1'b1, 1'b0, 1'b0, 0);
    check_eq("idx_5", {24'd0, bus.room_idx}, 5);
    run_exit(1'b1, 1'b0, 1'b0, 0);
    check_eq("idx_6", {24'd0, bus.room_idx}, 6);
    check_eq("room_is_stepper", {24'd0, bus.room}, {24'd0, map});

    // Back to 0, then wrap downward
    for (int i = 0; i < 6; i++) run_exit(1'b0, 1'b1, 1'b0, 0);
    check_eq("idx_0", {24'd0, bus.room_idx}, 0);
    run_exit(1'b0, 1'b1, 1'b0, 0);
    check_eq("idx_wrap_down", {24'd0, bus.room_idx}, 254);
    run_exit(1'b0, 1'b1, 1'b0, 0);
    check_eq("idx_253", {24'd0, bus.room_idx}, 253);

    // Underground right exit wraps upward by 3
    run_exit(1'b1, 1'b0, 1'b1, 0);
    check_eq("idx_wrap_up_ug", {24'd0, bus.room_idx}, 1);

    // Both exits at once are ignored
    @(negedge clk);
    bus.exit_right = 1'b1;
    bus.exit_left  = 1'b1;
    @(posedge clk);
    #1;
    bus.exit_right = 1'b0;
    bus.exit_left  = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.step !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    check_eq("both_exits_ignored", bad, 0);

    // Re-pulse during an active transition is dropped
    run_exit(1'b1, 1'b0, 1'b0, 4);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.step !== 1'b0) bad++;
    end
    check_eq("repulse_not_queued", bad, 0);

    // Reset during BLANK aborts the transition
    @(negedge clk);
    bus.exit_right = 1'b1;
    @(posedge clk);
    #1;
    bus.exit_right = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("in_blank_busy", {31'd0, bus.busy}, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("abort_blank", {31'd0, bus.blank}, 1);
    check_eq("abort_busy", {31'd0, bus.busy}, 1);
    check_eq("abort_room", {24'd0, bus.room}, 32'hC4);
    check_eq("abort_idx", {24'd0, bus.room_idx}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_room = 8'hC4;
    exp_idx  = 0;
    repeat (25) @(negedge clk);
    check_eq("recover_busy", {31'd0, bus.busy}, 0);
    check_eq("recover_room", {24'd0, bus.room}, 32'hC4);
    check_eq("recover_idx", {24'd0, bus.room_idx}, 0);
    check_eq("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/room_sequencer.md
Name: room_sequencer

Overview:
- Sequences the 8-bit map LFSR stepper on every screen exit and owns the committed room byte seen by the scene/video logic.
- Converts player exit events into LFSR steps, and blanks the display while the stepper advances.
  - Above ground: 1 step.
  - Underground: UNDERGROUND_STEPS steps.
- Maintains the room index modulo 255, matching the LFSR period.

Parameters:
- START_SEED, 8'hC4, room byte loaded at power-up and shown as room 0; must be non-zero.
- UNDERGROUND_STEPS, 3, LFSR steps per underground exit; legal range 1-15.
- BLANK_CYCLES, 16, cycles blank is held after the final step; minimum 1.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- exit_right  in  1  1-cycle pulse, player crossed right edge.
- exit_left  in  1  1-cycle pulse, player crossed left edge.
- underground  in  1  level flag, sampled with the exit pulse.
- map_in  in  8  current stepper output; valid the cycle after step or load_seed.
- step  out  1  1-cycle strobe, stepper advances once.
- dir  out  1  stepper direction; 1 = right/left-shift, 0 = left/right-shift; stable from accept to done.
- load_seed  out  1  1-cycle strobe, stepper loads seed_out.
- seed_out  out  8  constant START_SEED.
- room  out  8  committed room byte.
- room_idx  out  8  committed room index, 0..254.
- blank  out  1  video blank.
- busy  out  1  transition in progress; exits are ignored while high.
- done  out  1  1-cycle pulse on commit.

Behaviour:
- Reset asserted, asynchronous:
  - state=LOAD.
  - room=START_SEED, room_idx=0.
  - step=0, load_seed=0, dir=1, done=0.
  - blank=1, busy=1.
- Reset mid-transition aborts the transition: no step, no done, room/room_idx return to reset values.
- States: LOAD, SYNC, IDLE, STEP, WAIT, BLANK, COMMIT.
- LOAD:
  - First cycle after Reset deasserts.
  - load_seed=1 for exactly one cycle, then go to SYNC.
- SYNC:
  - room<=map_in.
  - Go to IDLE; blank and busy fall on entry to IDLE.
- IDLE:
  - busy=0, blank=0.
  - Exactly one of exit_right/exit_left high at an edge E0 = accept.
  - On accept:
    - dir<=exit_right.
    - steps_left<=(underground ? UNDERGROUND_STEPS : 1); keep a copy as n_steps.
    - Go to STEP.
  - Both exits high at once is ignored: no state change.
- STEP:
  - step=1 for this cycle only.
  - Go to WAIT.
- WAIT:
  - steps_left decrements.
  - If it reaches 0, go to BLANK with blank counter=BLANK_CYCLES; else go to STEP.
  - step is never high in two consecutive cycles.
- BLANK:
  - Counter decrements each cycle.
  - Go to COMMIT when counter reaches 1.
  - Occupies exactly BLANK_CYCLES cycles.
- COMMIT, one cycle:
  - room<=map_in.
  - room_idx<=room_idx±n_steps mod 255: + if dir=1, − if dir=0.
  - done=1; go to IDLE.
- Timing from accept edge E0, with N steps:
  - step is high in cycles 1, 3, …, 2N−1.
  - BLANK occupies cycles 2N+1 .. 2N+BLANK_CYCLES.
  - done is high in cycle 2N+BLANK_CYCLES+1, with the new room/room_idx visible from that cycle onward.
  - blank and busy are high in cycles 1 .. 2N+BLANK_CYCLES+1.
- Index arithmetic uses 9-bit intermediates:
  - Increment: 254+1→0, 253+3→1.
  - Decrement: 0−1→254, 1−3→253.
  - Index 255 is never produced.
- Exit pulses arriving while busy are dropped, not queued.
- underground is sampled only at accept; later changes have no effect.
- room changes only in SYNC and COMMIT, never mid-transition.

Test Plan:
- Reset low 3 cycles then high:
  - load_seed=1 in the first cycle only, seed_out=8'hC4.
  - Bench stepper returns C4; busy=0 three cycles after deassert.
  - room=C4, room_idx=0.
- exit_right, underground=0, from idx 5:
  - One step pulse, dir=1.
  - done at cycle 2+16+1=19.
  - room_idx=6; room equals the stepper's next value.
- exit_left at idx 0:
  - dir=0, one step.
  - room_idx=254 at done.
- exit_right, underground=1, at idx 253:
  - Exactly 3 step pulses at cycles 1, 3, 5.
  - done at cycle 23; room_idx=1.
- Timing and sequencing, from IDLE:
  - exit_left and exit_right together: no step, busy stays 0.
  - exit_right re-pulsed at cycle 4 of an active transition: ignored, exactly one step total.
- Round trip and mid-transition reset:
  - 255 consecutive exit_right transitions: room returns to C4 and room_idx to 0.
  - Reset asserted during BLANK: blank=1, busy=1, room=C4, idx=0 immediately; done never pulses.
